// File: rtl/daq_pkt_pkg.sv
// Shared packet-format definitions for the DAQ packetizer and the USB streamer.
package daq_pkt_pkg;

  localparam int unsigned WORD_W                = 16;
  localparam logic [15:0] PREAMBLE_VAL          = 16'hAAAA;
  localparam int unsigned DEFAULT_PAYLOAD_WORDS = 64;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_PKTEND  = 2'd3
  } pkt_state_e;

  function automatic logic is_preamble(input logic [WORD_W-1:0] word);
    return word == PREAMBLE_VAL;
  endfunction

endpackage

// File: rtl/daq_skid_buf.sv
// Two-entry buffer behind a FIFO with one cycle of read latency. The word
// arriving from the FIFO is presented directly when the buffer is empty.
module daq_skid_buf
  import daq_pkt_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              fifo_empty_i,
  input  logic [WORD_W-1:0] fifo_rd_data_i,
  input  logic              pop_i,
  output logic              fifo_rd_en_o,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o
);

  logic [WORD_W-1:0] mem_q [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q;
  logic              bypass, store, pop_mem;

  // NOTE: always_comb assigns every output first, so no path can infer a latch.
  always_comb begin
    bypass   = (count_q == 2'd0) && inflight_q && pop_i;
    store    = inflight_q && !bypass;
    pop_mem  = pop_i && (count_q != 2'd0);
    count_d  = count_q + {1'b0, store} - {1'b0, pop_mem};
    wr_ptr_d = wr_ptr_q ^ store;
    rd_ptr_d = rd_ptr_q ^ pop_mem;
  end

  // count_d already includes this cycle's pop and arrival, which is what lets
  // a read issue every cycle while the consumer keeps up.
  assign fifo_rd_en_o = !reset_i && !fifo_empty_i && (count_d < 2'd2);
  assign valid_o      = (count_q != 2'd0) || inflight_q;
  assign data_o       = (count_q != 2'd0) ? mem_q[rd_ptr_q] : fifo_rd_data_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= fifo_rd_en_o;
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (store) mem_q[wr_ptr_q] <= fifo_rd_data_i;
  end

endmodule

// File: rtl/daq_usb_streamer.sv
// Aligns on the packet preamble, checks header counter continuity and forwards
// whole packets from the DAQ packet FIFO to the FX2 slave-FIFO bus.
module daq_usb_streamer
  import daq_pkt_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = DEFAULT_PAYLOAD_WORDS,
  parameter bit          PKTEND_EN     = 1'b0,
  parameter logic [1:0]  FX2_EP_ADR    = 2'b10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [WORD_W-1:0] fifo_rd_data_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  output logic [WORD_W-1:0] fx2_fd_o,
  output logic              fx2_slwr_n_o,
  output logic              fx2_pktend_n_o,
  output logic [1:0]        fx2_fifoadr_o,
  input  logic              fx2_full_n_i,
  output logic [15:0]       pkt_count_o,
  output logic [15:0]       drop_count_o,
  output logic              seq_err_o
);

  localparam int unsigned      CNT_W    = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAYLOAD_WORDS - 1);

  pkt_state_e        state_q, state_d;
  logic              buf_valid;
  logic [WORD_W-1:0] buf_data;
  logic              pop, fwd, drop, pktend, hunt_hit, last_word;

  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [15:0]       exp_seq_q, exp_seq_d;
  logic              seq_valid_q, seq_valid_d;
  logic              seq_err_q, seq_err_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic [WORD_W-1:0] fd_q, fd_d;
  logic              slwr_n_q, slwr_n_d;
  logic              pktend_n_q, pktend_n_d;

  daq_skid_buf u_skid_buf (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .pop_i          (pop),
    .fifo_rd_en_o   (fifo_rd_en_o),
    .valid_o        (buf_valid),
    .data_o         (buf_data)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_HUNT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HUNT:    if (fwd)       state_d = ST_HEADER;
      ST_HEADER:  if (fwd)       state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (last_word) state_d = PKTEND_EN ? ST_PKTEND : ST_HUNT;
      ST_PKTEND:  if (pktend)    state_d = ST_HUNT;
      default:                   state_d = ST_HUNT;
    endcase
  end

  // Junk is dropped regardless of the FX2; a preamble waits for room so the
  // packet is never split from its first word.
  always_comb begin
    pop      = 1'b0;
    fwd      = 1'b0;
    drop     = 1'b0;
    pktend   = 1'b0;
    hunt_hit = en_i && is_preamble(buf_data);
    unique case (state_q)
      ST_HUNT: begin
        if (buf_valid && !hunt_hit) begin
          pop  = 1'b1;
          drop = 1'b1;
        end else if (buf_valid && fx2_full_n_i) begin
          pop = 1'b1;
          fwd = 1'b1;
        end
      end
      ST_HEADER, ST_PAYLOAD: begin
        pop = buf_valid && fx2_full_n_i;
        fwd = pop;
      end
      ST_PKTEND: pktend = fx2_full_n_i;
      default: ;
    endcase
    last_word = (state_q == ST_PAYLOAD) && fwd && (word_cnt_q == LAST_IDX);
  end

  always_comb begin
    fd_d         = fwd ? buf_data : fd_q;
    slwr_n_d     = !fwd;
    pktend_n_d   = !pktend;
    word_cnt_d   = word_cnt_q;
    exp_seq_d    = exp_seq_q;
    seq_valid_d  = seq_valid_q;
    seq_err_d    = seq_err_q;
    pkt_count_d  = last_word ? pkt_count_q + 16'd1 : pkt_count_q;
    drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
    if (state_q == ST_HEADER && fwd) begin
      if (seq_valid_q && buf_data != exp_seq_q) seq_err_d = 1'b1;
      exp_seq_d   = buf_data + 16'd1;
      seq_valid_d = 1'b1;
      word_cnt_d  = '0;
    end else if (state_q == ST_PAYLOAD && fwd) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      word_cnt_q   <= '0;
      exp_seq_q    <= 16'd0;
      seq_valid_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      pkt_count_q  <= 16'd0;
      drop_count_q <= 16'd0;
      fd_q         <= '0;
      slwr_n_q     <= 1'b1;
      pktend_n_q   <= 1'b1;
    end else begin
      word_cnt_q   <= word_cnt_d;
      exp_seq_q    <= exp_seq_d;
      seq_valid_q  <= seq_valid_d;
      seq_err_q    <= seq_err_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      fd_q         <= fd_d;
      slwr_n_q     <= slwr_n_d;
      pktend_n_q   <= pktend_n_d;
    end
  end

  assign fx2_fd_o       = fd_q;
  assign fx2_slwr_n_o   = slwr_n_q;
  assign fx2_pktend_n_o = pktend_n_q;
  assign fx2_fifoadr_o  = FX2_EP_ADR;
  assign pkt_count_o    = pkt_count_q;
  assign drop_count_o   = drop_count_q;
  assign seq_err_o      = seq_err_q;

endmodule
